// File: rtl/red_pitaya_lpf_pkg.sv
// Shared helpers for the cascaded one-pole filter: bit-width math, the
// bandwidth-derived shift limit and signed saturation.
package red_pitaya_lpf_pkg;

    localparam int CLK_HZ = 125_000_000;

    // Smallest n with 2**n >= value (0 for value <= 1).
    function automatic int clog2(input longint value);
        int result = 0;
        for (int i = 0; i < 63; i++) begin
            if ((longint'(1) << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Largest useful shift: the pole cannot sit below MINBW Hz at CLK_HZ.
    function automatic int calc_maxshift(input int minbw);
        return clog2(longint'(CLK_HZ) / longint'(minbw));
    endfunction

    // Clamp a signed value into the range of a signed 'width'-bit word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/red_pitaya_lpf_stage.sv
// One first-order section: accumulator y, registered error delta and a
// registered output selectable between lowpass, highpass and pass-through.
module red_pitaya_lpf_stage
    import red_pitaya_lpf_pkg::*;
#(
    parameter int SHIFTBITS  = 4,
    parameter int SIGNALBITS = 14,
    parameter int MAXSHIFT   = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear,
    input  logic [SHIFTBITS:0]           shift,
    input  logic                         highpass,
    input  logic                         filter_on,
    input  logic signed [SIGNALBITS-1:0] x,
    output logic signed [SIGNALBITS-1:0] out
);

    localparam int YW   = SIGNALBITS + MAXSHIFT;
    localparam int DW   = SIGNALBITS + 1;
    localparam int SUMW = YW + 2;

    logic signed [YW-1:0]         y;
    logic signed [DW-1:0]         delta;
    logic signed [SIGNALBITS-1:0] yout;
    logic signed [SUMW-1:0]       step;
    logic signed [SUMW-1:0]       sum;
    logic signed [YW-1:0]         y_next;
    logic signed [DW-1:0]         delta_next;
    logic signed [SIGNALBITS-1:0] hp_val;
    logic signed [SIGNALBITS-1:0] out_next;
    int                           shift_amt;

    // The accumulator keeps tracking even while the stage is bypassed, so
    // re-enabling it does not start from a stale state.
    always_comb begin
        shift_amt  = (int'(shift) > MAXSHIFT) ? MAXSHIFT : int'(shift);
        yout       = y[YW-1:MAXSHIFT];
        delta_next = DW'(x) - DW'(yout);
        step       = SUMW'(delta) <<< shift_amt;
        sum        = SUMW'(y) + step;
        y_next     = YW'(sat(64'(sum), YW));
        hp_val     = SIGNALBITS'(sat(64'(delta), SIGNALBITS));
        if (!filter_on) begin
            out_next = x;
        end else if (highpass) begin
            out_next = hp_val;
        end else begin
            out_next = yout;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            y     <= '0;
            delta <= '0;
            out   <= '0;
        end else begin
            y     <= y_next;
            delta <= delta_next;
            out   <= out_next;
        end
    end

endmodule

// File: rtl/red_pitaya_lpf_cascade.sv
// Cascade of one-pole filter sections with shadowed configuration applied on
// an update strobe and a settle counter that flags when the output is valid.
module red_pitaya_lpf_cascade
    import red_pitaya_lpf_pkg::*;
#(
    parameter int STAGES     = 4,
    parameter int SHIFTBITS  = 4,
    parameter int SIGNALBITS = 14,
    parameter int MINBW      = 10
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [STAGES*(SHIFTBITS+1)-1:0]   shifts_i,
    input  logic [STAGES-1:0]                 highpass_i,
    input  logic [STAGES-1:0]                 filter_on_i,
    input  logic                              update_i,
    input  logic                              clear_i,
    input  logic signed [SIGNALBITS-1:0]      signal_i,
    output logic signed [SIGNALBITS-1:0]      signal_o,
    output logic                              settled_o
);

    localparam int SW       = SHIFTBITS + 1;
    localparam int MAXSHIFT = calc_maxshift(MINBW);
    localparam int SETTLE   = STAGES + 2;
    localparam int CNTW     = clog2(SETTLE + 1);

    logic [STAGES*SW-1:0] shifts_q;
    logic [STAGES-1:0]    highpass_q;
    logic [STAGES-1:0]    filter_on_q;
    logic [CNTW-1:0]      settle_cnt;

    logic signed [SIGNALBITS-1:0] chain [STAGES+1];

    // Shadow configuration: only an update strobe moves the inputs into use.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shifts_q    <= '0;
            highpass_q  <= '0;
            filter_on_q <= '0;
        end else if (update_i) begin
            shifts_q    <= shifts_i;
            highpass_q  <= highpass_i;
            filter_on_q <= filter_on_i;
        end
    end

    // Any strobe restarts the settle window; it covers the full chain latency.
    always_ff @(posedge clk_i) begin
        if (rst_i || update_i || clear_i) begin
            settle_cnt <= CNTW'(SETTLE);
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNTW'(1);
        end
    end

    assign settled_o = (settle_cnt == '0);
    assign chain[0]  = signal_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        red_pitaya_lpf_stage #(
            .SHIFTBITS (SHIFTBITS),
            .SIGNALBITS(SIGNALBITS),
            .MAXSHIFT  (MAXSHIFT)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear    (clear_i),
            .shift    (shifts_q[k*SW +: SW]),
            .highpass (highpass_q[k]),
            .filter_on(filter_on_q[k]),
            .x        (chain[k]),
            .out      (chain[k+1])
        );
    end

    assign signal_o = chain[STAGES];

endmodule

// File: tb/tb_red_pitaya_lpf_cascade.sv
// Self-checking bench for red_pitaya_lpf_cascade: constant vector table plus
// directed and random sequences compared against an arithmetic reference model.
module tb_red_pitaya_lpf_cascade;

    localparam int STAGES     = 4;
    localparam int SHIFTBITS  = 4;
    localparam int SIGNALBITS = 14;
    localparam int MAXSHIFT   = 24;
    localparam int SETTLE     = STAGES + 2;
    localparam int SW         = SHIFTBITS + 1;
    localparam longint YMAX   = (longint'(1) <<< (SIGNALBITS + MAXSHIFT - 1)) - 1;
    localparam longint YMIN   = -(longint'(1) <<< (SIGNALBITS + MAXSHIFT - 1));

    logic                          clk = 1'b0;
    logic                          rst_i = 1'b1;
    logic [STAGES*SW-1:0]          shifts_i = '0;
    logic [STAGES-1:0]             highpass_i = '0;
    logic [STAGES-1:0]             filter_on_i = '0;
    logic                          update_i = 1'b0;
    logic                          clear_i = 1'b0;
    logic signed [SIGNALBITS-1:0]  signal_i = '0;
    logic signed [SIGNALBITS-1:0]  signal_o;
    logic                          settled_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint mY[STAGES];
    int     mDelta[STAGES];
    int     mOut[STAGES];
    int     mShift[STAGES];
    bit     mHp[STAGES];
    bit     mOn[STAGES];
    int     mCnt = SETTLE;

    always #4 clk = ~clk;

    red_pitaya_lpf_cascade #(
        .STAGES(STAGES), .SHIFTBITS(SHIFTBITS), .SIGNALBITS(SIGNALBITS), .MINBW(10)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .shifts_i(shifts_i), .highpass_i(highpass_i),
        .filter_on_i(filter_on_i), .update_i(update_i), .clear_i(clear_i),
        .signal_i(signal_i), .signal_o(signal_o), .settled_o(settled_o)
    );

    function automatic longint clampL(input longint v, input longint lo, input longint hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [STAGES*SW-1:0] packShifts(input int s0, input int s1,
                                                        input int s2, input int s3);
        logic [STAGES*SW-1:0] r;
        r = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
        return r;
    endfunction

    // One clock of the filter cascade, straight from the stage equations.
    task automatic modelClock();
        longint nY[STAGES];
        int     nDelta[STAGES];
        int     nOut[STAGES];
        int     x, yout, s;
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                mY[k] = 0; mDelta[k] = 0; mOut[k] = 0;
                mShift[k] = 0; mHp[k] = 0; mOn[k] = 0;
            end
            mCnt = SETTLE;
            return;
        end
        for (int k = 0; k < STAGES; k++) begin
            x = (k == 0) ? int'(signal_i) : mOut[k-1];
            yout = int'(mY[k] >>> MAXSHIFT);
            s = (mShift[k] > MAXSHIFT) ? MAXSHIFT : mShift[k];
            nDelta[k] = x - yout;
            nY[k] = clampL(mY[k] + longint'(mDelta[k]) * (longint'(1) <<< s), YMIN, YMAX);
            if (!mOn[k]) nOut[k] = x;
            else if (mHp[k]) nOut[k] = int'(clampL(longint'(mDelta[k]), -8192, 8191));
            else nOut[k] = yout;
        end
        for (int k = 0; k < STAGES; k++) begin
            mY[k]     = clear_i ? 0 : nY[k];
            mDelta[k] = clear_i ? 0 : nDelta[k];
            mOut[k]   = clear_i ? 0 : nOut[k];
            if (update_i) begin
                mShift[k] = int'(shifts_i[k*SW +: SW]);
                mHp[k]    = highpass_i[k];
                mOn[k]    = filter_on_i[k];
            end
        end
        if (update_i || clear_i) mCnt = SETTLE;
        else if (mCnt > 0) mCnt--;
    endtask

    task automatic tick();
        @(posedge clk);
        modelClock();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int sig, input bit upd, input bit clr);
        rst_i    = 1'b0;
        update_i = upd;
        clear_i  = clr;
        signal_i = SIGNALBITS'(sig);
        tick();
        update_i = 1'b0;
        clear_i  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int expSig, input bit expSettled);
        checks++;
        if (int'(signal_o) != expSig) begin
            errors++;
            $display("[TB] FAIL %s signal_o: got %0d, expected %0d", name, signal_o, expSig);
        end
        checks++;
        if (settled_o != expSettled) begin
            errors++;
            $display("[TB] FAIL %s settled_o: got %0b, expected %0b", name, settled_o, expSettled);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mOut[STAGES-1], (mCnt == 0));
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    typedef struct {
        bit rst;
        bit upd;
        int sig;
        int expSig;
        bit expSettled;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int peak, low;

        // Reset, then full bypass: 4-cycle latency and 6-cycle settle window.
        vecs[0]  = '{1, 0, 0,    0,    0};
        vecs[1]  = '{0, 1, 0,    0,    0};
        vecs[2]  = '{0, 0, 1234, 0,    0};
        vecs[3]  = '{0, 0, 1234, 0,    0};
        vecs[4]  = '{0, 0, 1234, 0,    0};
        vecs[5]  = '{0, 0, 1234, 1234, 0};
        vecs[6]  = '{0, 0, 1234, 1234, 0};
        vecs[7]  = '{0, 0, 1234, 1234, 1};
        vecs[8]  = '{0, 0, -77,  1234, 1};
        vecs[9]  = '{0, 0, -77,  1234, 1};
        vecs[10] = '{0, 0, -77,  1234, 1};
        vecs[11] = '{0, 0, -77,  -77,  1};

        for (int i = 0; i < 12; i++) begin
            rst_i    = vecs[i].rst;
            update_i = vecs[i].upd;
            clear_i  = 1'b0;
            signal_i = SIGNALBITS'(vecs[i].sig);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].expSig, vecs[i].expSettled);
            checkModel($sformatf("vec%0d_model", i));
        end
        update_i = 1'b0;

        // Lowpass step on stage 0 only.
        shifts_i = packShifts(23, 0, 0, 0); highpass_i = 4'b0000; filter_on_i = 4'b0001;
        applyStimulus(0, 1, 1); checkModel("lp_cfg");
        repeat (4) begin applyStimulus(0, 0, 0); checkModel("lp_zero"); end
        repeat (70) begin applyStimulus(1000, 0, 0); checkModel("lp_step"); end
        checkRange("lp_final", int'(signal_o), 999, 1001);

        // Highpass step: peaks at the step height, then decays with a faster pole.
        shifts_i = packShifts(10, 0, 0, 0); highpass_i = 4'b0001; filter_on_i = 4'b0001;
        applyStimulus(0, 1, 1); checkModel("hp_cfg");
        repeat (4) begin applyStimulus(0, 0, 0); checkModel("hp_zero"); end
        peak = -100000;
        repeat (200) begin
            applyStimulus(1000, 0, 0); checkModel("hp_step");
            if (int'(signal_o) > peak) peak = int'(signal_o);
        end
        checkRange("hp_peak", peak, 1000, 1000);
        shifts_i = packShifts(20, 0, 0, 0);
        applyStimulus(1000, 1, 0); checkModel("hp_fast_cfg");
        repeat (400) begin applyStimulus(1000, 0, 0); checkModel("hp_decay"); end
        checkRange("hp_final", int'(signal_o), -1, 1);

        // Saturation: settle lowpass at negative full scale, flip to highpass, step up.
        shifts_i = packShifts(20, 0, 0, 0); highpass_i = 4'b0000; filter_on_i = 4'b0001;
        applyStimulus(-8192, 1, 1); checkModel("sat_cfg");
        repeat (400) begin applyStimulus(-8192, 0, 0); checkModel("sat_lp"); end
        checkRange("sat_lp_settled", int'(signal_o), -8192, -8192);
        shifts_i = packShifts(16, 0, 0, 0); highpass_i = 4'b0001;
        applyStimulus(-8192, 1, 0); checkModel("sat_hp_cfg");
        peak = -100000; low = 100000;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8191, 0, 0); checkModel("sat_step");
            if (i >= 4) begin
                if (int'(signal_o) > peak) peak = int'(signal_o);
                if (int'(signal_o) < low) low = int'(signal_o);
            end
        end
        checkRange("sat_peak", peak, 8191, 8191);
        checkRange("sat_nonneg", low, 0, 8191);

        // Shadow config: input changes without update must not matter.
        shifts_i = packShifts(12, 5, 3, 8); highpass_i = 4'b0101; filter_on_i = 4'b1111;
        applyStimulus(0, 1, 1); checkModel("shadow_cfg");
        repeat (100) begin
            applyStimulus(int'($urandom_range(0, 16383)) - 8192, 0, 0); checkModel("shadow_run");
        end
        repeat (60) begin
            shifts_i = STAGES*SW'($urandom); highpass_i = 4'($urandom); filter_on_i = 4'($urandom);
            applyStimulus(int'($urandom_range(0, 16383)) - 8192, 0, 0); checkModel("shadow_ignore");
        end
        applyStimulus(int'($urandom_range(0, 16383)) - 8192, 1, 1);
        checkOutput("strobe_both", 0, 0);
        for (int i = 1; i < SETTLE; i++) begin
            applyStimulus(int'($urandom_range(0, 16383)) - 8192, 0, 0);
            checkOutput("strobe_settling", mOut[STAGES-1], 0);
        end
        applyStimulus(0, 0, 0);
        checkOutput("strobe_settled", mOut[STAGES-1], 1);

        // Random configs (including clamped and marginal shifts) and strobes.
        for (int i = 0; i < 1500; i++) begin
            bit upd, clr;
            upd = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 79) == 0);
            if (upd) begin
                shifts_i = STAGES*SW'($urandom); highpass_i = 4'($urandom); filter_on_i = 4'($urandom);
            end
            applyStimulus(int'($urandom_range(0, 16383)) - 8192, upd, clr);
            checkModel("random");
        end

        // Reset while filtering returns to bypass with cleared state.
        shifts_i = packShifts(15, 15, 15, 15); highpass_i = 4'b0000; filter_on_i = 4'b1111;
        applyStimulus(5000, 1, 1); checkModel("rst_cfg");
        repeat (200) begin applyStimulus(5000, 0, 0); checkModel("rst_run"); end
        rst_i = 1'b1; signal_i = SIGNALBITS'(5000);
        tick();
        checkOutput("rst_mid", 0, 0);
        applyStimulus(321, 0, 0); checkModel("rst_bypass1");
        applyStimulus(321, 0, 0); checkModel("rst_bypass2");
        applyStimulus(321, 0, 0); checkOutput("rst_bypass3", 0, 0);
        applyStimulus(321, 0, 0); checkOutput("rst_bypass4", 321, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
